sram_ctrl: RTL and testbench
============================

SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter DEPTH, 64, number of 32-bit words in the backing store (power of two).
REQ-002 Parameter WAIT_CYCLES, 5, number of BUSY cycles per access (minimum 1).
REQ-003 Parameter BASE_ADDR, 1024, byte address mapped to word 0.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; synchronous and active-low.
REQ-006 mem_read  input  1  read request from the MEM pipeline stage.
REQ-007 mem_write  input  1  write request from the MEM pipeline stage.
REQ-008 address  input  32  byte address of the access.
REQ-009 write_data  input  32  store data.
REQ-010 read_data  output  32  load data, registered.
REQ-011 ready  output  1  high when the current request is complete; low stalls the pipeline.
REQ-012 err  output  1  out-of-range flag (only with SRAM_CTRL_RANGE_CHK_EN).

Function
REQ-013 Word index SHALL be (address - BASE_ADDR) >> 2; address bits [1:0] ignored.
REQ-014 FSM states SHALL be IDLE, BUSY, DONE.
REQ-015 IDLE: on (mem_read | mem_write), latch address, write_data, and op; load counter with WAIT_CYCLES-1; go BUSY. Otherwise stay in IDLE.
REQ-016 BUSY: decrement counter each cycle; when counter is 0, commit the write or register the read into read_data on that edge, then go DONE.
REQ-017 DONE: unconditionally go IDLE next cycle; a request still asserted in IDLE starts a new transaction.
REQ-018 ready SHALL be combinational: 0 when (mem_read | mem_write) and state is not DONE; otherwise 1.
REQ-019 Latency: ready is low for WAIT_CYCLES+1 cycles starting with the request cycle, then high for exactly one cycle (DONE).
REQ-020 With no request, ready SHALL be 1 and the FSM SHALL stay in IDLE.
REQ-021 mem_read and mem_write both high: treated as a write; read_data holds its previous value.
REQ-022 Request inputs changing or dropping during BUSY SHALL NOT affect the latched transaction, which completes.
REQ-023 read_data SHALL hold its value until the next read completes; writes do not alter it.
REQ-024 Without range check, the word index SHALL wrap modulo DEPTH.

Reset
REQ-025 rst low at a clock edge: state becomes IDLE, counter 0, read_data 0, err 0.
REQ-026 Reset during BUSY SHALL abort the transaction; a pending write SHALL NOT be committed.
REQ-027 Backing-store contents SHALL NOT be cleared by reset.

Configuration
REQ-028 Macro SRAM_CTRL_RANGE_CHK_EN defined: err exists; an index >= DEPTH or address < BASE_ADDR drops the write, returns read_data 0, and sets err high during the DONE cycle only.
REQ-029 Macro SRAM_CTRL_RANGE_CHK_EN undefined: err port absent; no range checking; indices wrap per REQ-024.

Verification
REQ-030 Write: mem_write=1, address=1028, write_data=0xDEADBEEF, then read at 1028 -> ready low 6 cycles, high 1 cycle; read_data=0xDEADBEEF in the DONE cycle.
REQ-031 Idle: no request for 10 cycles -> ready=1 throughout; read_data unchanged.
REQ-032 Back-to-back: requests held continuously for two reads (1024, 1032) -> two DONE pulses 7 cycles apart with the correct data each.
REQ-033 Reset mid-op: write 0x12345678 to 1040, rst=0 in the 3rd BUSY cycle, then read 1040 -> old value returned; FSM in IDLE with read_data=0 right after reset.
REQ-034 Conflict: mem_read=mem_write=1, address=1044, data=0xA5A5A5A5 -> memory updated; read_data unchanged; a later read returns 0xA5A5A5A5.
REQ-035 Range (macro on): read at address 1024+4*64 -> err=1 in the DONE cycle only; read_data=0. Macro off: the same read returns word 0.

Source files
------------

// File: rtl/sram_ctrl.sv
// Wait-state SRAM controller: IDLE -> BUSY (WAIT_CYCLES) -> DONE handshake for a MEM pipeline stage.
// Define SRAM_CTRL_RANGE_CHK_EN to add the err port and out-of-range access suppression.
module sram_ctrl #(
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_CYCLES = 5,
    parameter int unsigned BASE_ADDR   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
`ifdef SRAM_CTRL_RANGE_CHK_EN
    output logic        err,
`endif
    output logic        ready
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               we_q, we_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               mem_we;

    logic [31:0]        mem_q [DEPTH];

    logic        req;
    logic [31:0] offset;
    logic [IDX_W-1:0] req_idx;

    assign req     = mem_read | mem_write;
    assign offset  = address - BASE_ADDR;
    // Truncating the word offset to IDX_W bits gives the modulo-DEPTH wrap.
    assign req_idx = IDX_W'(offset >> 2);

`ifdef SRAM_CTRL_RANGE_CHK_EN
    logic oob_q, oob_d;
    logic err_q, err_d;
    logic req_oob;

    assign req_oob = (address < BASE_ADDR) || ((offset >> 2) >= 32'(DEPTH));
    assign err     = err_q;
`endif

    assign ready     = !(req && (state_q != DONE));
    assign read_data = rdata_q;

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        mem_we  = 1'b0;
`ifdef SRAM_CTRL_RANGE_CHK_EN
        oob_d   = oob_q;
        err_d   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    idx_d   = req_idx;
                    wdata_d = write_data;
                    we_d    = mem_write;
                    cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                    state_d = BUSY;
`ifdef SRAM_CTRL_RANGE_CHK_EN
                    oob_d   = req_oob;
`endif
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
`ifdef SRAM_CTRL_RANGE_CHK_EN
                    err_d  = oob_q;
                    mem_we = we_q && !oob_q;
                    if (!we_q) rdata_d = oob_q ? 32'd0 : mem_q[idx_q];
`else
                    mem_we = we_q;
                    if (!we_q) rdata_d = mem_q[idx_q];
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
`ifdef SRAM_CTRL_RANGE_CHK_EN
            oob_q   <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
`ifdef SRAM_CTRL_RANGE_CHK_EN
            oob_q   <= oob_d;
            err_q   <= err_d;
`endif
        end
    end

    // NOTE: the store has no reset; reset only masks the commit so an aborted write never lands.
    always_ff @(posedge clk) begin
        if (rst && mem_we) mem_q[idx_q] <= wdata_q;
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed self-checking bench for sram_ctrl: latency, data path, back-to-back, reset abort, conflict, range.
module tb_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic        ready;
`ifdef SRAM_CTRL_RANGE_CHK_EN
    logic        err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_ctrl #(
        .DEPTH      (64),
        .WAIT_CYCLES(5),
        .BASE_ADDR  (1024)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .address   (address),
        .write_data(write_data),
        .read_data (read_data),
`ifdef SRAM_CTRL_RANGE_CHK_EN
        .err       (err),
`endif
        .ready     (ready)
    );

    // Issues one request at a negedge and samples ready #1 after each negedge until DONE.
    task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [31:0] d, input bit keep,
                              output int low_cnt, output bit done,
                              output logic [31:0] rdata, output logic err_o);
        @(negedge clk);
        mem_read = rd; mem_write = wr; address = a; write_data = d;
        low_cnt = 0; done = 1'b0; rdata = '0; err_o = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            #1;
            if (ready) begin
                done  = 1'b1;
                rdata = read_data;
`ifdef SRAM_CTRL_RANGE_CHK_EN
                err_o = err;
`endif
            end else begin
                low_cnt++;
                @(negedge clk);
            end
        end
        if (!keep) begin mem_read = 1'b0; mem_write = 1'b0; end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL access_timeout addr=%0d: got no ready, expected ready within 20 cycles", a);
        end
    endtask

    task automatic write_word(input logic [31:0] a, input logic [31:0] d);
        int lc; bit dn; logic [31:0] rv; logic e;
        run_access(1'b0, 1'b1, a, d, 1'b0, lc, dn, rv, e);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
        checks++;
        if (read_data !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h expected 00000000", read_data); end
`ifdef SRAM_CTRL_RANGE_CHK_EN
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
`endif
        rst = 1'b1;
    endtask

    task automatic test_write_read();
        int lc; bit dn; logic [31:0] rv; logic e;
        run_access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 1'b0, lc, dn, rv, e);
        checks++;
        if (lc !== 6) begin errors++; $display("FAIL write_latency: got %0d expected 6", lc); end
        checks++;
        if (rv !== 32'd0) begin errors++; $display("FAIL write_rdata_hold: got %h expected 00000000", rv); end
        run_access(1'b1, 1'b0, 32'd1028, 32'd0, 1'b1, lc, dn, rv, e);
        checks++;
        if (lc !== 6) begin errors++; $display("FAIL read_latency: got %0d expected 6", lc); end
        checks++;
        if (rv !== 32'hDEADBEEF) begin errors++; $display("FAIL read_data: got %h expected deadbeef", rv); end
        // Request still held: the cycle after DONE restarts, so ready must drop again.
        @(negedge clk); #1;
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL done_one_cycle: got %b expected 0", ready); end
        mem_read = 1'b0;
        repeat (7) @(negedge clk);
    endtask

    task automatic test_idle();
        int bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (ready !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL idle_ready: got %0d low cycles expected 0", bad); end
        checks++;
        if (read_data !== 32'hDEADBEEF) begin errors++; $display("FAIL idle_rdata: got %h expected deadbeef", read_data); end
    endtask

    task automatic test_back_to_back();
        int n_done = 0;
        int done_cyc [2];
        logic [31:0] data [2];
        write_word(32'd1024, 32'h11111111);
        write_word(32'd1032, 32'h22222222);
        @(negedge clk);
        mem_read = 1'b1; address = 32'd1024;
        for (int i = 0; i < 40 && n_done < 2; i++) begin
            #1;
            if (ready) begin
                done_cyc[n_done] = i;
                data[n_done] = read_data;
                n_done++;
                address = 32'd1032;
            end
            @(negedge clk);
        end
        mem_read = 1'b0;
        checks++;
        if (n_done != 2) begin
            errors++; $display("FAIL b2b_done_count: got %0d expected 2", n_done);
        end else begin
            checks++;
            if (done_cyc[0] != 6) begin errors++; $display("FAIL b2b_first_done: got %0d expected 6", done_cyc[0]); end
            checks++;
            if (done_cyc[1] - done_cyc[0] != 7) begin
                errors++; $display("FAIL b2b_spacing: got %0d expected 7", done_cyc[1] - done_cyc[0]);
            end
            checks++;
            if (data[0] !== 32'h11111111) begin errors++; $display("FAIL b2b_data0: got %h expected 11111111", data[0]); end
            checks++;
            if (data[1] !== 32'h22222222) begin errors++; $display("FAIL b2b_data1: got %h expected 22222222", data[1]); end
        end
    endtask

    task automatic test_reset_mid_op();
        int lc; bit dn; logic [31:0] rv; logic e;
        write_word(32'd1040, 32'hCAFEF00D);
        @(negedge clk);
        mem_write = 1'b1; address = 32'd1040; write_data = 32'h12345678;
        repeat (3) @(negedge clk);
        rst = 1'b0; mem_write = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b expected 1", ready); end
        checks++;
        if (read_data !== 32'd0) begin errors++; $display("FAIL rst_mid_rdata: got %h expected 00000000", read_data); end
        rst = 1'b1;
        run_access(1'b1, 1'b0, 32'd1040, 32'd0, 1'b0, lc, dn, rv, e);
        checks++;
        if (lc !== 6) begin errors++; $display("FAIL rst_mid_idle_latency: got %0d expected 6", lc); end
        checks++;
        if (rv !== 32'hCAFEF00D) begin errors++; $display("FAIL rst_mid_old_value: got %h expected cafef00d", rv); end
    endtask

    task automatic test_conflict();
        int lc; bit dn; logic [31:0] rv; logic e;
        run_access(1'b1, 1'b1, 32'd1044, 32'hA5A5A5A5, 1'b0, lc, dn, rv, e);
        checks++;
        if (rv !== 32'hCAFEF00D) begin errors++; $display("FAIL conflict_rdata_hold: got %h expected cafef00d", rv); end
        run_access(1'b1, 1'b0, 32'd1044, 32'd0, 1'b0, lc, dn, rv, e);
        checks++;
        if (rv !== 32'hA5A5A5A5) begin errors++; $display("FAIL conflict_mem: got %h expected a5a5a5a5", rv); end
    endtask

    task automatic test_input_change();
        int lc; bit dn; logic [31:0] rv; logic e;
        write_word(32'd1052, 32'h55555555);
        @(negedge clk);
        mem_write = 1'b1; address = 32'd1048; write_data = 32'h0BADC0DE;
        @(negedge clk);
        mem_write = 1'b0; address = 32'd1052; write_data = 32'hFFFFFFFF;
        repeat (6) @(negedge clk);
        run_access(1'b1, 1'b0, 32'd1048, 32'd0, 1'b0, lc, dn, rv, e);
        checks++;
        if (rv !== 32'h0BADC0DE) begin errors++; $display("FAIL latched_write: got %h expected 0badc0de", rv); end
        run_access(1'b1, 1'b0, 32'd1052, 32'd0, 1'b0, lc, dn, rv, e);
        checks++;
        if (rv !== 32'h55555555) begin errors++; $display("FAIL latched_other_word: got %h expected 55555555", rv); end
    endtask

    task automatic test_range();
        int lc; bit dn; logic [31:0] rv; logic e;
        write_word(32'd1276, 32'h3F3F3F3F);
        run_access(1'b1, 1'b0, 32'd1031, 32'd0, 1'b0, lc, dn, rv, e);
        checks++;
        if (rv !== 32'hDEADBEEF) begin errors++; $display("FAIL byte_bits_ignored: got %h expected deadbeef", rv); end
        run_access(1'b1, 1'b0, 32'd1276, 32'd0, 1'b0, lc, dn, rv, e);
        checks++;
        if (rv !== 32'h3F3F3F3F || e !== 1'b0) begin
            errors++; $display("FAIL last_word: got %h err %b expected 3f3f3f3f err 0", rv, e);
        end
`ifdef SRAM_CTRL_RANGE_CHK_EN
        run_access(1'b1, 1'b0, 32'd1280, 32'd0, 1'b0, lc, dn, rv, e);
        checks++;
        if (rv !== 32'd0 || e !== 1'b1) begin
            errors++; $display("FAIL range_high: got %h err %b expected 00000000 err 1", rv, e);
        end
        @(negedge clk); #1;
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL range_err_pulse: got %b expected 0", err); end
        run_access(1'b0, 1'b1, 32'd1280, 32'h99999999, 1'b0, lc, dn, rv, e);
        run_access(1'b1, 1'b0, 32'd1024, 32'd0, 1'b0, lc, dn, rv, e);
        checks++;
        if (rv !== 32'h11111111) begin errors++; $display("FAIL range_write_dropped: got %h expected 11111111", rv); end
        run_access(1'b1, 1'b0, 32'd1020, 32'd0, 1'b0, lc, dn, rv, e);
        checks++;
        if (rv !== 32'd0 || e !== 1'b1) begin
            errors++; $display("FAIL range_low: got %h err %b expected 00000000 err 1", rv, e);
        end
`else
        run_access(1'b1, 1'b0, 32'd1280, 32'd0, 1'b0, lc, dn, rv, e);
        checks++;
        if (rv !== 32'h11111111) begin errors++; $display("FAIL wrap_high: got %h expected 11111111", rv); end
        run_access(1'b1, 1'b0, 32'd1020, 32'd0, 1'b0, lc, dn, rv, e);
        checks++;
        if (rv !== 32'h3F3F3F3F) begin errors++; $display("FAIL wrap_low: got %h expected 3f3f3f3f", rv); end
`endif
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_idle();
        test_back_to_back();
        test_reset_mid_op();
        test_conflict();
        test_input_change();
        test_range();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
